// File: rtl/fetch_buffered_if.sv
// Fetch unit bus: instruction-memory request/response, redirect input,
// decoded-stage handshake and sticky status flags.
interface fetch_buffered_if #(
   parameter int WIDTH = 16
);
   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic             imem_valid;
   logic [WIDTH-1:0] imem_rdata;
   logic             redirect;
   logic [WIDTH-1:0] redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] instr_out;
   logic [WIDTH-1:0] pc_incr_out;
   logic             halted;
   logic             unaligned_err;

   modport master (
      output imem_req, imem_addr, out_valid, instr_out, pc_incr_out, halted, unaligned_err,
      input  imem_valid, imem_rdata, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, instr_out, pc_incr_out, halted, unaligned_err,
      output imem_valid, imem_rdata, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_buffered.sv
// Prefetching fetch unit with a DEPTH-entry queue, redirect squash and HALT stop.
// FETCH_ALIGN_CHECK_EN: odd fetch PC becomes an error NOP entry and stops fetch.
module fetch_buffered #(
   parameter int               WIDTH    = 16,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   fetch_buffered_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [WIDTH-1:0] NOP = {5'b00001, {(WIDTH-5){1'b0}}};

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] pc_incr;
      logic             err;
   } entry_t;

   typedef enum logic [2:0] {S_RUN, S_HALT_PEND, S_ERR_PEND, S_HALTED, S_ERR_STOP} state_t;

   state_t           state, state_n;
   entry_t           q [DEPTH];
   entry_t           enq_entry;
   logic [PW-1:0]    head, tail;
   logic [CW-1:0]    occ, inflight, drop;
   logic [WIDTH-1:0] pc, resp_addr;
   logic             stopped, redir, room, resp, resp_keep, resp_halt;
   logic             can_fetch, issue, err_fire, enq, deq, out_valid, head_halt;

   always_comb begin
      stopped   = (state == S_HALTED) || (state == S_ERR_STOP);
      redir     = bus.redirect && !stopped;
      room      = ({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(DEPTH);
      resp      = bus.imem_valid && (inflight != '0);
      resp_keep = resp && (drop == '0) && (state == S_RUN);
      resp_halt = resp_keep && (bus.imem_rdata[WIDTH-1 -: 5] == 5'b00000);
      // kept responses are the newest in-flight requests, contiguous up to pc-2
      resp_addr = pc - WIDTH'({inflight, 1'b0});
      // an arriving HALT blocks the request in the same cycle
      can_fetch = !rst && (state == S_RUN) && !bus.redirect && room && !resp_halt;
`ifdef FETCH_ALIGN_CHECK_EN
      issue     = can_fetch && !pc[0];
      err_fire  = can_fetch && pc[0] && (inflight == '0);
`else
      issue     = can_fetch;
      err_fire  = 1'b0;
`endif
      out_valid = (occ != '0) && !stopped;
      deq       = out_valid && bus.out_ready && !redir;
      enq       = !redir && (resp_keep || err_fire);
      head_halt = (q[head].instr[WIDTH-1 -: 5] == 5'b00000);
      enq_entry = '{instr: bus.imem_rdata, pc_incr: resp_addr + WIDTH'(2), err: 1'b0};
      if (err_fire)
         enq_entry = '{instr: NOP, pc_incr: pc + WIDTH'(2), err: 1'b1};
   end

   always_comb begin
      state_n = state;
      if (redir)
         state_n = S_RUN;
      else begin
         case (state)
            S_RUN:       if (resp_halt) state_n = S_HALT_PEND;
                         else if (err_fire) state_n = S_ERR_PEND;
            S_HALT_PEND: if (deq && head_halt) state_n = S_HALTED;
            S_ERR_PEND:  if (deq && q[head].err) state_n = S_ERR_STOP;
            default:     state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RUN;
         pc       <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         occ      <= '0;
         inflight <= '0;
         drop     <= '0;
      end else begin
         state    <= state_n;
         inflight <= inflight + CW'(issue) - CW'(resp);
         if (redir)
            pc <= bus.redirect_pc;
         else if (issue)
            pc <= pc + WIDTH'(2);
         // everything still outstanding at a redirect belongs to the old path
         if (redir)
            drop <= inflight - CW'(resp);
         else if (resp && (drop != '0))
            drop <= drop - CW'(1);
         if (redir) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
         end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            occ <= occ + CW'(enq) - CW'(deq);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) q[tail] <= enq_entry;
   end

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = pc;
   assign bus.out_valid   = out_valid;
   assign bus.instr_out   = out_valid ? q[head].instr : NOP;
   assign bus.pc_incr_out = out_valid ? q[head].pc_incr : '0;
   assign bus.halted      = (state == S_HALTED);
`ifdef FETCH_ALIGN_CHECK_EN
   assign bus.unaligned_err = (state == S_ERR_STOP);
`else
   assign bus.unaligned_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_buffered.sv
// Scoreboard bench for fetch_buffered: random-latency memory, random backpressure,
// redirects and resets against an address-sequence reference model.
module tb_fetch_buffered;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam logic [15:0] NOP = 16'h0800;

   typedef struct { logic [15:0] instr; logic [15:0] pc_incr; bit halt; bit err; } item_t;
   typedef struct { logic [15:0] addr; int due; } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_buffered_if #(.WIDTH(WIDTH)) bus ();
   fetch_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pops   = 0;
   int          cyc      = 0;
   int          last_due = 0;
   int          lat_min  = 1;
   int          lat_max  = 1;
   int          due;
   logic [15:0] halt_addr = 16'h0001;
   logic [15:0] gen_pc;
   bit          gen_done, m_halted, m_err;
   item_t       exp_q [$];
   item_t       mon_item;
   rsp_t        rq [$];
   logic [15:0] req_log [$];

   function automatic logic [15:0] mem_f(logic [15:0] a);
      logic [15:0] h;
      h = (a * 16'h9E37) ^ 16'h5A5A;
      return (a == halt_addr) ? 16'h0000 : {1'b1, h[14:0]};
   endfunction

   // reference model: expected output stream from the current fetch target
   function automatic void fill();
      while (!gen_done && exp_q.size() < 16) begin
         item_t it;
         it.instr   = mem_f(gen_pc);
         it.pc_incr = gen_pc + 16'd2;
         it.halt    = (it.instr[15:11] == 5'b00000);
         it.err     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         if (gen_pc[0]) begin
            it.instr = NOP;
            it.halt  = 1'b0;
            it.err   = 1'b1;
         end
`endif
         gen_done = it.halt || it.err;
         exp_q.push_back(it);
         gen_pc = gen_pc + 16'd2;
      end
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         fill();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect = 1'b0;
      exp_q.delete();
      req_log.delete();
      gen_pc   = RESET_PC;
      gen_done = 1'b0;
      m_halted = 1'b0;
      m_err    = 1'b0;
      fill();
      step(8);
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_instr_out", bus.instr_out, NOP);
      chk("rst_pc_incr_out", bus.pc_incr_out, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_unaligned_err", bus.unaligned_err, 0);
      rst = 1'b0;
   endtask

   task automatic do_redirect(logic [15:0] t);
      bus.redirect    = 1'b1;
      bus.redirect_pc = t;
      if (!(m_halted || m_err)) begin
         exp_q.delete();
         gen_pc   = t;
         gen_done = 1'b0;
         fill();
      end
      step();
      bus.redirect = 1'b0;
   endtask

   // memory: log requests, answer in order after lat_min..lat_max cycles
   initial forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rq.push_back('{addr: bus.imem_addr, due: due});
         req_log.push_back(bus.imem_addr);
      end
   end

   initial begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = mem_f(rq[0].addr);
            void'(rq.pop_front());
         end else begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = 16'($urandom);
         end
      end
   end

   // monitor: pop an expectation on every accepted output
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("halted", bus.halted, 32'(m_halted));
         chk("unaligned_err", bus.unaligned_err, 32'(m_err));
         if (m_halted || m_err) begin
            chk("stopped_out_valid", bus.out_valid, 0);
            chk("stopped_imem_req", bus.imem_req, 0);
         end
         if (bus.out_valid !== 1'b1) chk("idle_instr_nop", bus.instr_out, NOP);
         if (bus.out_valid === 1'b1 && bus.out_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got pc_incr %0h expected no output", bus.pc_incr_out);
            end else begin
               mon_item = exp_q.pop_front();
               n_pops++;
               chk("instr_out", bus.instr_out, mon_item.instr);
               chk("pc_incr_out", bus.pc_incr_out, mon_item.pc_incr);
               if (mon_item.halt) m_halted = 1'b1;
               if (mon_item.err) m_err = 1'b1;
            end
         end
      end
   end

   initial begin
      int          t_req, t_ov, n;
      logic [15:0] a, rtgt;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.out_ready   = 1'b0;

      // first-fetch latency and address sequence with a 1-cycle memory
      lat_min = 1; lat_max = 1;
      bus.out_ready = 1'b1;
      do_reset();
      t_req = -1; t_ov = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.imem_req === 1'b1 && t_req < 0) t_req = k;
         if (bus.out_valid === 1'b1 && t_ov < 0) t_ov = k;
      end
      step();
      chk("first_req_cycle", t_req, 0);
      chk("req_to_valid_latency", t_ov - t_req, 2);
      a = (req_log.size() > 2) ? req_log[2] : 16'hDEAD;
      chk("third_req_addr", {req_log.size() > 2, a}, {1'b1, 16'h0004});

      // backpressure: queue plus in-flight capped at DEPTH
      lat_min = 1; lat_max = 3;
      bus.out_ready = 1'b0;
      do_reset();
      step(12);
      chk("full_req_count", req_log.size(), DEPTH);
      chk("full_imem_req", bus.imem_req, 0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      step(8);
      chk("one_pop_one_req", req_log.size(), DEPTH + 1);

      // redirect with three requests in flight
      lat_min = 3; lat_max = 3;
      do_reset();
      for (int k = 0; k < 20 && req_log.size() < 3; k++) step();
      chk("inflight_reqs", req_log.size(), 3);
      do_redirect(16'h0100);
      chk("redirect_clears_valid", bus.out_valid, 0);
      step(3);
      a = (req_log.size() > 3) ? req_log[3] : 16'hDEAD;
      chk("redirect_target_addr", a, 16'h0100);
      bus.out_ready = 1'b1;
      lat_min = 1;
      step(20);

      // PC wraps at the top of the address space
      n = req_log.size();
      do_redirect(16'hFFFC);
      step(15);
      a = (req_log.size() > n + 2) ? req_log[n+2] : 16'hDEAD;
      chk("wrap_addr", a, 16'h0000);

      // HALT at 0x0006
      halt_addr = 16'h0006;
      lat_min = 1; lat_max = 1;
      do_reset();
      step(20);
      chk("halt_halted", bus.halted, 1);
      chk("halt_req_count", req_log.size(), 4);
      do_redirect(16'h0040);
      step(5);
      chk("halt_ignores_redirect", req_log.size(), 4);
      chk("halt_sticky", bus.halted, 1);
      halt_addr = 16'h0001;

      // misaligned redirect target
      lat_min = 1; lat_max = 3;
      do_reset();
      step(6);
      n = req_log.size();
      do_redirect(16'h0011);
      step(15);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("odd_no_request", req_log.size(), n);
      chk("odd_unaligned_err", bus.unaligned_err, 1);
`else
      a = (req_log.size() > n) ? req_log[n] : 16'hDEAD;
      chk("odd_addr_issued", a, 16'h0011);
      chk("odd_unaligned_err", bus.unaligned_err, 0);
`endif

      // random traffic: backpressure, redirects, occasional mid-run reset
      do_reset();
      for (int k = 0; k < 4000; k++) begin
         bus.out_ready = ($urandom_range(9, 0) < 7);
         if ($urandom_range(39, 0) == 0) begin
            rtgt = 16'($urandom);
            rtgt[0] = 1'b0;
            do_redirect(rtgt);
         end else if ($urandom_range(699, 0) == 0) begin
            do_reset();
         end else begin
            step();
         end
      end
      bus.out_ready = 1'b1;
      step(20);
      chk("traffic_volume", n_pops > 200, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_buffered.md
FETCH_BUFFERED -- requirements
Module: fetch_buffered

Interface
REQ-001 Parameter: WIDTH, 16, instruction/PC width; legal range >= 8.
REQ-002 Parameter: DEPTH, 4, prefetch queue entries; power of 2, >= 2.
REQ-003 Parameter: RESET_PC, 0, PC loaded on reset.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 imem_req  out  1  fetch request issued this cycle.
REQ-008 imem_addr  out  WIDTH  fetch address (current PC).
REQ-009 imem_valid  in  1  in-order response strobe, latency >= 1 cycle.
REQ-010 imem_rdata  in  WIDTH  response instruction.
REQ-011 redirect  in  1  squash plus PC load (branch/jump resolved).
REQ-012 redirect_pc  in  WIDTH  new PC.
REQ-013 out_valid  out  1  instr_out/pc_incr_out valid.
REQ-014 out_ready  in  1  downstream accepts.
REQ-015 instr_out  out  WIDTH  head instruction; 16'h0800-style NOP ({5'b00001, zeros}) when out_valid=0.
REQ-016 pc_incr_out  out  WIDTH  head instruction address + 2.
REQ-017 halted  out  1  HALT retired; sticky until rst.
REQ-018 unaligned_err  out  1  misaligned fetch PC retired (see Configuration); sticky until rst.

Function
REQ-019 Request issued when: not halt_pending, not err_pending, not halted, redirect=0, (occupancy + in-flight) < DEPTH.
REQ-020 Each issued request increments PC by 2 (mod 2^WIDTH, wrap at top) next cycle.
REQ-021 Response enqueues {imem_rdata, address+2} at tail same cycle imem_valid=1, unless dropped (REQ-024).
REQ-022 Dequeue on out_valid & out_ready; simultaneous enqueue/dequeue with queue full or empty legal, occupancy unchanged.
REQ-023 No combinational path imem_rdata -> instr_out; min latency request -> out_valid = imem latency + 1 cycle.
REQ-024 redirect=1: queue cleared next cycle, PC <= redirect_pc, halt_pending/err_pending cleared, all in-flight responses counted and discarded; no request that cycle.
REQ-025 redirect wins over simultaneous dequeue and enqueue; out_valid=0 the cycle after.
REQ-026 Enqueued instruction with bits [WIDTH-1:WIDTH-5]=5'b00000 sets halt_pending; requests stop; in-flight responses after it discarded.
REQ-027 halted asserts the cycle after the HALT instruction is dequeued; thereafter out_valid=0, imem_req=0, redirect ignored.
REQ-028 Occupancy counter width clog2(DEPTH)+1; never exceeds DEPTH; in-flight counter never exceeds DEPTH.

Reset
REQ-029 On rst: PC=RESET_PC, queue empty, in-flight=0, imem_req=0, out_valid=0, instr_out=NOP, pc_incr_out=0, halted=0, unaligned_err=0, pending flags clear.
REQ-030 rst mid-operation discards queue and in-flight responses; responses arriving after rst deasserts for pre-reset requests are dropped via cleared in-flight tracking (imem_valid with in-flight=0 ignored).

Configuration
REQ-031 Macro FETCH_ALIGN_CHECK_EN defined: PC[0]=1 at issue time sets err_pending, no request issued, a NOP entry tagged error enqueued; unaligned_err asserts cycle after that entry dequeues; fetch then stops as for HALT.
REQ-032 Macro undefined: PC[0] ignored, address issued unchanged, unaligned_err tied 0.

Verification
REQ-033 Reset RESET_PC=0x0000, 1-cycle memory, out_ready=1 -> addresses 0,2,4 issued; out_valid first high cycle 3; pc_incr_out 2,4,6.
REQ-034 DEPTH=4, out_ready=0 -> exactly 4 requests, then imem_req=0; out_ready=1 for one cycle -> one new request.
REQ-035 3 requests in flight, redirect to 0x0100 -> queue empty next cycle, 3 late responses dropped, next imem_addr=0x0100.
REQ-036 imem_rdata=0x0000 at address 0x0006 -> no request beyond it; halted=1 cycle after it dequeues; later redirect ignored.
REQ-037 FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x0011 -> no request, unaligned_err=1 after NOP entry dequeues; undefined -> imem_addr=0x0011, unaligned_err=0.
REQ-038 PC=0xFFFE, WIDTH=16 -> next request address 0x0000, pc_incr_out=0x0000.
